// File: rtl/controller_responder.sv
// controller_responder: serial game-pad responder for a latch/shift-clock host.
// Host latch and shift clock are synchronized, edge-detected, and drive a
// small LOAD/SHIFT/IDLE machine that streams the frozen button word out
// active-low in A, B, SELECT, START, UP, DOWN, LEFT, RIGHT order.
// Optional turbo on A/B is enabled by defining CTRL_RESPONDER_TURBO_EN.
module controller_responder #(
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_PERIOD = 4
) (
  input  logic       I_CLK_33MHZ,
  input  logic       I_RESET,
  input  logic       I_LATCH,
  input  logic       I_PULSE,
  input  logic [7:0] I_BUTTONS,
  input  logic [1:0] I_TURBO,
  output logic       O_DATA,
  output logic       O_FRAME,
  output logic [7:0] O_SNAPSHOT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  localparam logic [3:0] IDX_DONE = 4'd8;

  logic [SYNC_STAGES-1:0] latch_sync_reg;
  logic [SYNC_STAGES-1:0] pulse_sync_reg;
  logic                   latch_s;
  logic                   pulse_s;
  logic                   latch_q_reg;
  logic                   latch_fall_reg;
  logic                   pulse_q_reg;
  logic                   pulse_rise_reg;

  state_t                 state_reg;
  logic [3:0]             index_reg;
  logic [3:0]             index_next;
  logic [7:0]             snapshot_reg;
  logic                   data_reg;
  logic                   frame_reg;
  logic [7:0]             eff_buttons;

  assign latch_s = latch_sync_reg[SYNC_STAGES-1];
  assign pulse_s = pulse_sync_reg[SYNC_STAGES-1];

  // Shift-register synchronizers for the two asynchronous host lines.
  always_ff @(posedge I_CLK_33MHZ) begin
    if (I_RESET) begin
      latch_sync_reg <= '0;
      pulse_sync_reg <= '0;
    end else begin
      latch_sync_reg <= {latch_sync_reg[SYNC_STAGES-2:0], I_LATCH};
      pulse_sync_reg <= {pulse_sync_reg[SYNC_STAGES-2:0], I_PULSE};
    end
  end

  // Registered edge detect; latch level is delayed alongside so level and edges line up.
  always_ff @(posedge I_CLK_33MHZ) begin
    if (I_RESET) begin
      latch_q_reg    <= 1'b0;
      latch_fall_reg <= 1'b0;
      pulse_q_reg    <= 1'b0;
      pulse_rise_reg <= 1'b0;
    end else begin
      latch_q_reg    <= latch_s;
      latch_fall_reg <= latch_q_reg & ~latch_s;
      pulse_q_reg    <= pulse_s;
      pulse_rise_reg <= pulse_s & ~pulse_q_reg;
    end
  end

`ifdef CTRL_RESPONDER_TURBO_EN
  localparam int CW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [CW-1:0] turbo_cnt_reg;
  logic          turbo_phase_reg;

  // Frame counter advances on every completed latch; phase flips on wrap.
  always_ff @(posedge I_CLK_33MHZ) begin
    if (I_RESET) begin
      turbo_cnt_reg   <= '0;
      turbo_phase_reg <= 1'b0;
    end else if (latch_fall_reg) begin
      if (turbo_cnt_reg == CW'(TURBO_PERIOD - 1)) begin
        turbo_cnt_reg   <= '0;
        turbo_phase_reg <= ~turbo_phase_reg;
      end else begin
        turbo_cnt_reg <= turbo_cnt_reg + 1'b1;
      end
    end
  end

  // A and B are masked off during the inactive turbo phase when turbo is requested.
  always_comb begin
    eff_buttons    = I_BUTTONS;
    eff_buttons[4] = I_BUTTONS[4] & (~I_TURBO[0] | turbo_phase_reg);
    eff_buttons[5] = I_BUTTONS[5] & (~I_TURBO[1] | turbo_phase_reg);
  end
`else
  logic unused_turbo;
  assign unused_turbo = ^I_TURBO;

  // Without turbo the live buttons are used as-is.
  always_comb begin
    eff_buttons = I_BUTTONS;
  end
`endif

  // Active-low serial bit for a shift position; position 8 is the idle-high overrun.
  function automatic logic serial_bit(input logic [3:0] idx, input logic [7:0] snap);
    logic b;
    case (idx)
      4'd0:    b = ~snap[4];
      4'd1:    b = ~snap[5];
      4'd2:    b = ~snap[6];
      4'd3:    b = ~snap[7];
      4'd4:    b = ~snap[2];
      4'd5:    b = ~snap[3];
      4'd6:    b = ~snap[1];
      4'd7:    b = ~snap[0];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  // Shift index advance: only on pulse edges outside latch, saturating at the overrun slot.
  always_comb begin
    index_next = index_reg;
    if (!latch_q_reg && pulse_rise_reg && (index_reg != IDX_DONE)) begin
      index_next = index_reg + 4'd1;
    end
  end

  // Responder state machine with registered serial data, frame strobe and snapshot.
  always_ff @(posedge I_CLK_33MHZ) begin
    if (I_RESET) begin
      state_reg    <= S_IDLE;
      index_reg    <= IDX_DONE;
      snapshot_reg <= 8'h00;
      data_reg     <= 1'b1;
      frame_reg    <= 1'b0;
    end else if (latch_q_reg) begin
      state_reg    <= S_LOAD;
      index_reg    <= 4'd0;
      snapshot_reg <= eff_buttons;
      data_reg     <= ~eff_buttons[4];
      frame_reg    <= 1'b0;
    end else begin
      index_reg <= index_next;
      data_reg  <= serial_bit(index_next, snapshot_reg);
      frame_reg <= latch_fall_reg;
      case (state_reg)
        S_LOAD:  state_reg <= S_SHIFT;
        S_SHIFT: state_reg <= (index_next == IDX_DONE) ? S_IDLE : S_SHIFT;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign O_DATA     = data_reg;
  assign O_FRAME    = frame_reg;
  assign O_SNAPSHOT = snapshot_reg;

endmodule

// File: tb/tb_controller_responder.sv
// Bench for controller_responder: a frame-level reference model checked every
// cycle, plus directed frames with hand-computed serial streams.
module tb_controller_responder;

  localparam int S  = 2;
  localparam int TP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       latch;
  logic       pulse;
  logic [7:0] buttons;
  logic [1:0] turbo;
  logic       o_data;
  logic       o_frame;
  logic [7:0] o_snap;

  always #15 clk = ~clk;

  controller_responder #(.SYNC_STAGES(S), .TURBO_PERIOD(TP)) dut (
    .I_CLK_33MHZ(clk),
    .I_RESET    (rst),
    .I_LATCH    (latch),
    .I_PULSE    (pulse),
    .I_BUTTONS  (buttons),
    .I_TURBO    (turbo),
    .O_DATA     (o_data),
    .O_FRAME    (o_frame),
    .O_SNAPSHOT (o_snap)
  );

  int tests = 0;
  int fails = 0;
  int frames = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   order [8] = '{4, 5, 6, 7, 2, 3, 1, 0};
  logic hist_l [S+3];
  logic hist_p [S+3];
  logic m_valid = 1'b0;
  logic m_data;
  logic m_frame;
  logic [7:0] m_snap;
  int   m_idx;
  int   m_cnt;
  logic m_phase;

  function automatic logic [7:0] eff(input logic [7:0] b, input logic [1:0] t, input logic ph);
    logic [7:0] r;
    r = b;
`ifdef CTRL_RESPONDER_TURBO_EN
    if (t[0] && !ph) r[4] = 1'b0;
    if (t[1] && !ph) r[5] = 1'b0;
`endif
    return r;
  endfunction

  // Model updates at each rising edge, outputs compared at the following falling edge.
  initial begin
    logic cl, pl, cp, pp;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int j = 0; j < S + 3; j++) begin
          hist_l[j] = 1'b0;
          hist_p[j] = 1'b0;
        end
        m_data  = 1'b1;
        m_frame = 1'b0;
        m_snap  = 8'h00;
        m_idx   = 8;
        m_cnt   = 0;
        m_phase = 1'b0;
        m_valid = 1'b1;
      end else begin
        for (int j = S + 2; j > 0; j--) begin
          hist_l[j] = hist_l[j-1];
          hist_p[j] = hist_p[j-1];
        end
        hist_l[0] = latch;
        hist_p[0] = pulse;
        cl = hist_l[S+1];
        pl = hist_l[S+2];
        cp = hist_p[S+1];
        pp = hist_p[S+2];
        m_frame = 1'b0;
        if (cl) begin
          m_snap = eff(buttons, turbo, m_phase);
          m_idx  = 0;
        end else begin
          if (pl) begin
            m_frame = 1'b1;
            m_cnt++;
            if (m_cnt == TP) begin
              m_cnt   = 0;
              m_phase = ~m_phase;
            end
          end
          if (cp && !pp && m_idx < 8) m_idx++;
        end
        m_data = (m_idx >= 8) ? 1'b1 : ~m_snap[order[m_idx]];
      end
      @(negedge clk);
      if (m_valid) begin
        check("model_data", {7'b0, o_data}, {7'b0, m_data});
        check("model_frame", {7'b0, o_frame}, {7'b0, m_frame});
        check("model_snapshot", o_snap, m_snap);
      end
    end
  end

  // Frame strobe counter.
  initial begin
    forever begin
      @(negedge clk);
      if (o_frame === 1'b1) frames++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_frame();
    latch = 1'b1;
    wait_cyc(6);
    latch = 1'b0;
    wait_cyc(6);
  endtask

  task automatic pulse_once();
    pulse = 1'b1;
    wait_cyc(4);
    pulse = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    logic seq29 [8];
    int   f0;
    logic exp33;
    seq29 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; latch = 1'b0; pulse = 1'b0; buttons = 8'h00; turbo = 2'b00;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);

    // Reset / idle state
    check("t028_data", {7'b0, o_data}, 8'h01);
    check("t028_frame", {7'b0, o_frame}, 8'h00);
    check("t028_snapshot", o_snap, 8'h00);

    // START, A, RIGHT
    buttons = 8'h91;
    f0 = frames;
    latch_frame();
    check("t029_snapshot", o_snap, 8'h91);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t029_bit%0d", k), {7'b0, o_data}, {7'b0, seq29[k]});
      pulse_once();
    end
    check("t029_overrun", {7'b0, o_data}, 8'h01);
    check("t029_frames", 8'(frames - f0), 8'h01);

    // All pressed, buttons released after latch, extra pulses
    buttons = 8'hFF;
    latch_frame();
    buttons = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t030_bit%0d", k), {7'b0, o_data}, 8'h00);
      pulse_once();
    end
    for (int k = 0; k < 2; k++) begin
      pulse_once();
      check($sformatf("t030_extra%0d", k), {7'b0, o_data}, 8'h01);
    end
    check("t030_snapshot", o_snap, 8'hFF);

    // Pulse during latch high is ignored
    buttons = 8'h20;
    latch = 1'b1;
    wait_cyc(6);
    pulse_once();
    latch = 1'b0;
    wait_cyc(6);
    check("t031_bitA", {7'b0, o_data}, 8'h01);
    pulse_once();
    check("t031_bitB", {7'b0, o_data}, 8'h00);
    check("t031_snapshot", o_snap, 8'h20);

    // Reset mid-shift, then a fresh full frame
    buttons = 8'hFF;
    latch_frame();
    for (int k = 0; k < 3; k++) pulse_once();
    check("t032_pre_reset", {7'b0, o_data}, 8'h00);
    rst = 1'b1;
    wait_cyc(1);
    check("t032_reset_data", {7'b0, o_data}, 8'h01);
    check("t032_reset_snapshot", o_snap, 8'h00);
    rst = 1'b0;
    wait_cyc(4);
    latch_frame();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t032_bit%0d", k), {7'b0, o_data}, 8'h00);
      pulse_once();
    end
    check("t032_overrun", {7'b0, o_data}, 8'h01);

    // Turbo on A across eight frames
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(4);
    buttons = 8'h10;
    turbo = 2'b01;
    for (int f = 0; f < 8; f++) begin
      latch_frame();
`ifdef CTRL_RESPONDER_TURBO_EN
      exp33 = ((f % 4) < 2) ? 1'b1 : 1'b0;
`else
      exp33 = 1'b0;
`endif
      check($sformatf("t033_frame%0d_first", f), {7'b0, o_data}, {7'b0, exp33});
    end

    wait_cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
